// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit type codes, input port indices and
// the output arbiter state type.
package noc_pkg;

  localparam logic [2:0] HEADER  = 3'b001;
  localparam logic [2:0] PAYLOAD = 3'b010;
  localparam logic [2:0] TAIL    = 3'b100;

  typedef enum logic [2:0] {
    N = 3'd0,
    E = 3'd1,
    W = 3'd2,
    S = 3'd3,
    L = 3'd4
  } port_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr,
// wrapping modulo NUM_IN. Shared with the VC allocator.
module rr_pick #(
  parameter int NUM_IN = 5,
  parameter int IDX_W  = 3
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_IN-1:0] win_oh,
  output logic [IDX_W-1:0]  win_idx,
  output logic              valid
);

  int cand;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    valid   = 1'b0;
    cand    = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_IN) cand = cand - NUM_IN;
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        win_oh[cand] = 1'b1;
        win_idx      = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/noc_out_arbiter.sv
// Per-output round-robin arbiter holding the grant for a whole packet.
// Optional packet-length watchdog: define ARB_WATCHDOG_EN.
//
// state | meaning
// IDLE  | no grant; arbitrate among req each cycle
// BUSY  | grant held until a TAIL transfer (or watchdog release)
module noc_out_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_IN        = 5,
  parameter int FLIT_ID_W     = 3,
  parameter int MAX_PKT_FLITS = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_IN-1:0]             req,
  input  logic [NUM_IN-1:0]             empty,
  input  logic [NUM_IN*FLIT_ID_W-1:0]   flit_id,
  input  logic                          out_full,
  output logic [NUM_IN-1:0]             grant,
  output logic [2:0]                    sel,
  output logic [NUM_IN-1:0]             rd_en,
  output logic                          wr_en,
  output logic                          err
);

  localparam int IDX_W = 3;

  arb_state_e        state_q, state_d;
  logic [NUM_IN-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;

  logic [NUM_IN-1:0]    pick_oh;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic [NUM_IN-1:0]    xfer_vec;
  logic [FLIT_ID_W-1:0] head_id;
  logic                 tail_xfer;
  logic                 release_pkt;

  rr_pick #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .valid   (pick_valid)
  );

  assign xfer_vec  = grant_q & ~empty & {NUM_IN{~out_full}};
  assign rd_en     = xfer_vec;
  assign wr_en     = |xfer_vec;
  assign head_id   = flit_id[sel_q*FLIT_ID_W +: FLIT_ID_W];
  assign tail_xfer = wr_en && (head_id == FLIT_ID_W'(TAIL));

`ifdef ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(MAX_PKT_FLITS + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             wd_hit;

  // Fires on the transfer that would make the count reach the limit.
  assign wd_hit = wr_en && !tail_xfer && (cnt_q == CNT_W'(MAX_PKT_FLITS - 1));
  assign err    = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    release_pkt = 1'b0;
`ifdef ARB_WATCHDOG_EN
    err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_oh;
          sel_d   = pick_idx;
          ptr_d   = (pick_idx == IDX_W'(NUM_IN - 1)) ? '0 : pick_idx + 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (tail_xfer) begin
          release_pkt = 1'b1;
        end
`ifdef ARB_WATCHDOG_EN
        else if (wd_hit) begin
          release_pkt = 1'b1;
          err_d       = 1'b1;
        end
`endif
        if (release_pkt) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef ARB_WATCHDOG_EN
    cnt_d = cnt_q;
    if (release_pkt)  cnt_d = '0;
    else if (wr_en)   cnt_d = cnt_q + 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
`ifdef ARB_WATCHDOG_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
`ifdef ARB_WATCHDOG_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;

endmodule
